// File: rtl/mrv32_lsu_gen2.sv
// Load/store unit: checks alignment and address window at acceptance, issues one
// port-B access, waits (bounded) for read data and extends it, then holds until mem_valid drops.
module mrv32_lsu_gen2 #(
  parameter int          MEM_BYTES      = 4096,
  parameter int          ADDR_WIDTH     = $clog2(MEM_BYTES),
  parameter logic [31:0] RAM_BASE       = 32'h0,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter bit          TRAP_EN        = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [3:0]            mem_wstrb,
  input  logic [2:0]            load_funct3,
  input  logic [31:0]           eff_addr,
  input  logic [31:0]           store_data,
  output logic                  lsu_done,
  output logic [31:0]           load_data,
  output logic                  lsu_fault,
  output logic [1:0]            fault_cause,
  output logic                  b_valid,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [31:0]           b_wdata,
  output logic [3:0]            b_wstrb,
  input  logic [31:0]           b_rdata,
  input  logic                  b_rvalid
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_DONE, S_HOLD} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_UNMAP = 2'b10;
  localparam logic [1:0] CAUSE_TMO = 2'b11;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Selects the addressed lane of a read word and extends it to 32 bits.
  function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sext);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    shifted = word >> {lane, 3'b000};
    b_s = shifted[7:0];
    h_s = shifted[15:0];
    ext = 32'sd0;
    case (size)
      SZ_B:    ext = sext ? 32'(b_s) : signed'({24'd0, shifted[7:0]});
      SZ_H:    ext = sext ? 32'(h_s) : signed'({16'd0, shifted[15:0]});
      default: ext = signed'(shifted);
    endcase
    return unsigned'(ext);
  endfunction

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  logic [1:0]            cause_q, cause_d;
  logic [31:0]           load_data_q, load_data_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d;
  logic [1:0]            lane_q, lane_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic                  store_q, store_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;

  logic [1:0]  req_size;
  logic [33:0] req_rel;
  logic [33:0] req_nbytes;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        req_misal;
  logic        req_unmap;

  // Request decode: size, window-relative offset and legality, all in 34 bits so nothing wraps.
  always_comb begin
    req_size = SZ_W;
    if (mem_wen) begin
      if (mem_wstrb == 4'b0001)      req_size = SZ_B;
      else if (mem_wstrb == 4'b0011) req_size = SZ_H;
    end else begin
      if (load_funct3[1:0] == 2'b00)      req_size = SZ_B;
      else if (load_funct3[1:0] == 2'b01) req_size = SZ_H;
    end
    case (req_size)
      SZ_B:    begin req_nbytes = 34'd1; req_mask = 4'b0001; req_wdata = {4{store_data[7:0]}};  end
      SZ_H:    begin req_nbytes = 34'd2; req_mask = 4'b0011; req_wdata = {2{store_data[15:0]}}; end
      default: begin req_nbytes = 34'd4; req_mask = 4'b1111; req_wdata = store_data;            end
    endcase
    req_misal = ((req_size == SZ_H) && eff_addr[0]) ||
                ((req_size == SZ_W) && (eff_addr[1:0] != 2'b00));
    req_rel   = {2'b00, eff_addr} - {2'b00, RAM_BASE};
    req_unmap = req_rel[33] || ((req_rel + req_nbytes) > 34'(MEM_BYTES));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    cause_d     = cause_q;
    load_data_d = load_data_q;
    off_d       = off_q;
    lane_d      = lane_q;
    size_d      = size_q;
    sext_d      = sext_q;
    store_d     = store_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          off_d   = req_rel[ADDR_WIDTH-1:0];
          lane_d  = eff_addr[1:0];
          size_d  = req_size;
          sext_d  = ~load_funct3[2];
          store_d = mem_wen;
          wdata_d = req_wdata;
          wstrb_d = req_mask << eff_addr[1:0];
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
          if (!mem_wen && !mem_ren) begin
            state_d = S_DONE;
          end else if (req_misal) begin
            state_d     = S_DONE;
            fault_d     = 1'b1;
            cause_d     = CAUSE_MISAL;
            load_data_d = 32'd0;
          end else if (req_unmap) begin
            state_d     = S_DONE;
            fault_d     = 1'b1;
            cause_d     = CAUSE_UNMAP;
            load_data_d = 32'd0;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = store_q ? S_DONE : S_WAIT_R;
      end
      S_WAIT_R: begin
        // Data arriving in the expiry cycle still completes normally.
        if (b_rvalid) begin
          load_data_d = lane_extend(b_rdata, lane_q, size_q, sext_q);
          state_d     = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          fault_d     = 1'b1;
          cause_d     = CAUSE_TMO;
          load_data_d = 32'd0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  if (!mem_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      fault_q     <= 1'b0;
      cause_q     <= CAUSE_NONE;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      load_data_q <= load_data_d;
    end
  end

  always_ff @(posedge clk) begin
    off_q   <= off_d;
    lane_q  <= lane_d;
    size_q  <= size_d;
    sext_q  <= sext_d;
    store_q <= store_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign lsu_done    = (state_q == S_DONE);
  assign lsu_fault   = TRAP_EN && lsu_done && fault_q;
  assign fault_cause = (TRAP_EN && lsu_done) ? cause_q : CAUSE_NONE;
  assign load_data   = load_data_q;
  assign b_valid     = (state_q == S_ISSUE);
  assign b_addr      = {off_q[ADDR_WIDTH-1:2], 2'b00};
  assign b_wdata     = wdata_q;
  assign b_wstrb     = (b_valid && store_q) ? wstrb_q : 4'b0000;

endmodule

// File: doc/mrv32_lsu_gen2.md
MRV32_LSU_GEN2 -- requirements
Module: mrv32_lsu_gen2

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096, meaning RAM window size in bytes (power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_BYTES), meaning port-B byte-address width.
REQ-003 SHALL have parameter RAM_BASE, default 32'h0, meaning first byte address of the RAM window.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum wait for b_rvalid (1..255).
REQ-005 SHALL have parameter TRAP_EN, default 1; 0 = legacy silent-suppress mode, 1 = fault reporting.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-007 SHALL have request ports: mem_valid in 1 request; mem_ren in 1 load; mem_wen in 1 store; mem_wstrb in 4 size kind (WSTRB_B/H/W); load_funct3 in 3 RV32 load funct3; eff_addr in 32 byte address; store_data in 32 store value (low bits).
REQ-008 SHALL have response ports: lsu_done out 1 one-cycle completion; load_data out 32 extended load result; lsu_fault out 1 fault flag, valid with lsu_done; fault_cause out 2 (00 none, 01 misaligned, 10 unmapped, 11 timeout).
REQ-009 SHALL have memory port B: b_valid out 1; b_addr out ADDR_WIDTH; b_wdata out 32; b_wstrb out 4 (0000 = read); b_rdata in 32; b_rvalid in 1.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT_R, DONE, HOLD.
REQ-011 IDLE: accepts a request when mem_valid=1 (cycle 0); mem_wen has priority over mem_ren; neither set -> DONE with no bus access and no fault.
REQ-012 Checks at acceptance: misaligned = halfword with addr[0]=1 or word with addr[1:0]!=0; unmapped = any byte of the access outside [RAM_BASE, RAM_BASE+MEM_BYTES), with no 32-bit wraparound.
REQ-013 Misaligned or unmapped request: IDLE->DONE, b_valid never asserted, no RAM write, load_data=0, cause 01 or 10 (misaligned takes precedence).
REQ-014 ISSUE: b_valid=1 for exactly one cycle; b_addr = (eff_addr-RAM_BASE) with bits [1:0] cleared; b_wstrb = size mask << addr[1:0] for stores, 0000 for loads; b_wdata = store byte/half replicated across all lanes.
REQ-015 ISSUE->DONE for stores (lsu_done in cycle 2); ISSUE->WAIT_R for loads.
REQ-016 WAIT_R: on b_rvalid, capture b_rdata, select lane by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU/LW), go to DONE; with read latency L, lsu_done is in cycle L+2.
REQ-017 WAIT_R counter: no b_rvalid within TIMEOUT_CYCLES cycles -> DONE, load_data=0, cause 11; b_rvalid in the expiry cycle wins (normal completion).
REQ-018 DONE: lsu_done=1 for one cycle, lsu_fault/fault_cause valid, then to HOLD.
REQ-019 HOLD: waits for mem_valid=0 before returning to IDLE, so a request held high after completion is never reissued.
REQ-020 load_data is registered and stays stable until the next load completes; stores do not alter it.
REQ-021 b_rvalid outside WAIT_R SHALL be ignored.
REQ-022 TRAP_EN=0: lsu_fault=0 and fault_cause=00 always; suppression behaviour of REQ-013/017 is otherwise unchanged.
REQ-023 Illegal load_funct3 (011, 110, 111) behaves as LW.

Reset
REQ-024 With rst_n=0 at a clk edge: state=IDLE, b_valid=0, b_wstrb=0, lsu_done=0, lsu_fault=0, fault_cause=00, load_data=0, timeout counter=0.
REQ-025 Reset in any state, including ISSUE/WAIT_R, SHALL abort the access; no lsu_done for the aborted request, and a later stray b_rvalid is ignored.

Verification
REQ-026 SW 0xA1B2C3D4 @0x100, then LW -> RAM bytes D4,C3,B2,A1 in order; LW returns 0xA1B2C3D4; load lsu_done in cycle 3 with L=1.
REQ-027 SB 0x80 @0x101 -> b_wstrb=0010; LB returns 0xFFFFFF80, LBU returns 0x00000080; SH 0x8001 @0x102 -> LH 0xFFFF8001, LHU 0x00008001.
REQ-028 LW @0x102 -> lsu_done in cycle 1, no b_valid, load_data=0, lsu_fault=1, cause 01; with TRAP_EN=0, lsu_fault=0.
REQ-029 SW 0xDEADBEEF @RAM_BASE+MEM_BYTES+32 -> cause 10, no b_valid; a following LW @0x100 does not return 0xDEADBEEF.
REQ-030 Load with b_rvalid held low, TIMEOUT_CYCLES=4 -> lsu_done 4 cycles into WAIT_R, cause 11, load_data=0; a late b_rvalid is ignored.
REQ-031 mem_valid held for 3 cycles after lsu_done -> exactly one b_valid pulse; reset asserted during WAIT_R -> no lsu_done, all outputs at reset values.
